// File: rtl/seq_scan_pkg.sv
// rtl/seq_scan_pkg.sv - shared types and defaults for the 1101 scan scheduler
// Contents:
//   sched_state_t : scheduler FSM states (IDLE, SHIFT, DONE)
//   det_state_t   : "1101" detector states (IDLE, S1, S11, S110)
//   DEF_WORD_W    : default data word width
package seq_scan_pkg;

   localparam int DEF_WORD_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } sched_state_t;

   typedef enum logic [1:0] {
      DET_IDLE = 2'd0,
      DET_S1   = 2'd1,
      DET_S11  = 2'd2,
      DET_S110 = 2'd3
   } det_state_t;

endpackage

// File: rtl/seq1101_det.sv
// rtl/seq1101_det.sv - overlapping "1101" Mealy sequence detector
// Ports:
//   clk : clock
//   rst : asynchronous active-high reset to DET_IDLE
//   clr : synchronous clear to DET_IDLE (wins over the bit on i)
//   i   : serial input bit
//   o   : Mealy output, 1 when i completes "1101"
module seq1101_det
   import seq_scan_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic i,
   output logic o
);

   det_state_t state;

   // Output depends on the current bit, so the match is counted in the
   // same cycle the final '1' is presented.
   assign o = (state == DET_S110) && i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DET_IDLE;
      end else if (clr) begin
         state <= DET_IDLE;
      end else begin
         case (state)
            DET_IDLE: state <= i ? DET_S1   : DET_IDLE;
            DET_S1:   state <= i ? DET_S11  : DET_IDLE;
            DET_S11:  state <= i ? DET_S11  : DET_S110;
            // The trailing '1' of a match is reused as the first '1' of the next.
            DET_S110: state <= i ? DET_S1   : DET_IDLE;
            default:  state <= DET_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/seq_scan_sched.sv
// rtl/seq_scan_sched.sv - two-requester round-robin "1101" word scanner
// Ports:
//   clk        : clock
//   rst        : asynchronous active-high reset
//   req_valid  : per-requester word valid
//   req_data   : requester r word at [r*WORD_W +: WORD_W]
//   req_ready  : per-requester accept strobe (only in IDLE)
//   res_valid  : result available
//   res_ready  : consumer accepts result
//   res_id     : requester that owns the result
//   res_count  : number of "1101" matches in the word
//   res_hit    : res_count != 0
module seq_scan_sched
   import seq_scan_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int CNT_W  = $clog2(WORD_W + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_valid,
   input  logic [2*WORD_W-1:0]   req_data,
   output logic [1:0]            req_ready,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  res_id,
   output logic [CNT_W-1:0]      res_count,
   output logic                  res_hit
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   sched_state_t      state;
   logic [WORD_W-1:0] sh_word;
   logic [IDX_W-1:0]  bit_idx;
   logic [CNT_W-1:0]  count;
   logic              last_gnt;
   logic              gnt;
   logic              accept;
   logic              det_o;
   logic [WORD_W-1:0] sel_word;

   // Both valid: take the one not granted last; otherwise take whichever is valid.
   always_comb begin
      gnt       = (req_valid == 2'b11) ? ~last_gnt : req_valid[1];
      req_ready = 2'b00;
      if (!rst && state == ST_IDLE && (|req_valid))
         req_ready = gnt ? 2'b10 : 2'b01;
      accept    = |(req_valid & req_ready);
      sel_word  = gnt ? req_data[2*WORD_W-1:WORD_W] : req_data[WORD_W-1:0];
   end

   // Detector is cleared on every accept so matches never span two words.
   seq1101_det u_det (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .i   (sh_word[WORD_W-1]),
      .o   (det_o)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         sh_word   <= '0;
         bit_idx   <= '0;
         count     <= '0;
         res_id    <= 1'b0;
         res_valid <= 1'b0;
         last_gnt  <= 1'b1;  // makes requester 0 win the first tie
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  sh_word  <= sel_word;
                  res_id   <= gnt;
                  last_gnt <= gnt;
                  bit_idx  <= '0;
                  count    <= '0;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               sh_word <= {sh_word[WORD_W-2:0], 1'b0};
               count   <= count + CNT_W'(det_o);
               bit_idx <= bit_idx + 1'b1;
               if (bit_idx == IDX_W'(WORD_W - 1)) begin
                  state     <= ST_DONE;
                  res_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  state     <= ST_IDLE;
                  res_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

   assign res_count = count;
   assign res_hit   = |count;

endmodule
